booth_div: RTL and testbench
============================

# booth_div

Sequential unsigned restoring divider. It is the inverse counterpart of the team's shift-add Booth multiplier and uses the same start/done handshake and datapath/controller split. It takes a W-bit dividend and a W-bit divisor and produces a W-bit quotient and a W-bit remainder after W iteration cycles. Divide-by-zero is flagged and short-circuited. It sits beside the multiplier in the arithmetic unit and is driven by the same sequencing logic.

## Interface
- W, 4: operand, quotient and remainder width; legal range is 2 or more.
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset; forces IDLE and clears all registers.
- x  input  W  dividend, sampled only on the edge that accepts start.
- y  input  W  divisor, sampled only on the edge that accepts start.
- start  input  1  request; accepted only while in IDLE.
- q  output  W  quotient, registered, holds the last result.
- r  output  W  remainder, registered, holds the last result.
- done  output  1  one-cycle pulse marking that q/r/dbz are newly valid.
- busy  output  1  high in CALC and DONE, low in IDLE.
- dbz  output  1  divide-by-zero flag for the last result, held with q/r.

## Operation
- Datapath registers:
  - A: W+1 bits, partial remainder.
  - Q: W bits, dividend shifting into the quotient.
  - Y: W bits, latched divisor.
  - cnt: ceil(log2(W+1)) bits.
  - Result registers q, r, dbz.
- Controller states: IDLE, CALC, DONE.
- IDLE, start=1, y≠0:
  - A←0, Q←x, Y←y, cnt←W.
  - Next state CALC.
- IDLE, start=1, y=0:
  - q←all ones, r←x, dbz←1.
  - Next state DONE. No iterations run.
- IDLE, start=0: stay in IDLE, all registers hold.
- CALC, one iteration per cycle:
  - Shift {A,Q} left by one.
  - T = A_shifted − {0,Y}, computed in W+1 bits.
  - If T[W]=1 (negative): keep A_shifted, Q[0]←0.
  - Else: A←T, Q[0]←1.
  - cnt←cnt−1.
  - On the iteration where cnt=1: q←final Q, r←final A[W−1:0], dbz←0, next state DONE.
- DONE:
  - done=1 for exactly this cycle.
  - Next state IDLE unconditionally.
  - start is ignored in DONE.
- start while busy (CALC or DONE) is ignored; operands are not re-sampled.
- q, r, dbz change only on entry to DONE and hold until the next result.
- Arithmetic:
  - Unsigned only.
  - Invariant: x = q·y + r, with r < y, for every y≠0.
  - A never exceeds W+1 bits and no overflow is possible.
- Reset:
  - Asynchronous; takes effect immediately, including mid-CALC.
  - After reset: state=IDLE, q=0, r=0, dbz=0, done=0, busy=0, A=Q=Y=cnt=0.
  - An operation interrupted by reset is abandoned and no done is produced.

## Timing
- Let edge 0 be the rising edge that samples start=1 in IDLE.
- Normal division:
  - Iterations occur on edges 1..W.
  - State is DONE after edge W; done is high from edge W to edge W+1.
  - q/r are valid from edge W onward.
  - busy is high from edge 0 to edge W+1.
- Divide-by-zero:
  - State is DONE after edge 0; done is high from edge 0 to edge 1.
  - q/r/dbz are valid from edge 0.
- Earliest next acceptance: edge W+2 for a normal division, edge 2 for divide-by-zero (the first edge seen in IDLE).
- If start is held high continuously, a new operation begins on every return to IDLE.
- done and busy are registered state decodes with no combinational path from inputs.

## Test plan
- Basic division, W=4: x=13, y=4, one-cycle start → done pulses once, 4 cycles after the accept edge; q=3, r=1, dbz=0; busy high for 5 cycles.
- Boundary operands, W=4:
  - 15/1 → q=15, r=0.
  - 3/5 → q=0, r=3.
  - 15/15 → q=1, r=0.
  - 0/7 → q=0, r=0.
- Divide-by-zero: x=7, y=0 → done in the cycle after the accept edge; q=15, r=7, dbz=1. A following 9/3 → q=3, r=0, dbz cleared to 0.
- Handshake robustness:
  - Pulse start again mid-CALC with different x/y → ignored, result unchanged.
  - Hold start high for 20 cycles → back-to-back results with exactly one idle cycle between done pulses.
- Reset mid-operation: assert reset asynchronously (between edges) 2 cycles into 13/4 → q, r, done, busy, dbz go to 0 immediately; no done follows. The next 10/3 gives q=3, r=1.
- Exhaustive self-check, W=4: all 256 (x, y) pairs → q=x/y and r=x%y for y≠0, dbz=1 for y=0, and exactly one done per accepted start.

Source files
------------

// File: rtl/booth_div.sv
// booth_div: sequential unsigned restoring divider with start/done handshake.
// Divide-by-zero is short-circuited: q=all ones, r=x, dbz=1.
module booth_div #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         start,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         done,
    output logic         busy,
    output logic         dbz
);
    localparam int CW = $clog2(W + 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_n;
    logic [W:0] a, a_sh, t, a_nx;
    logic [W-1:0] qr, yr, q_sh;
    logic [CW-1:0] cnt;
    logic unused;
    // a[W] is always 0 after a restore step; only the shifted copy needs the extra bit
    assign unused = a[W];
    assign done = state == DONE;
    assign busy = state != IDLE;
    always_comb begin
        a_sh = {a[W-1:0], qr[W-1]};
        t = a_sh - {1'b0, yr};
        a_nx = t[W] ? a_sh : t;
        q_sh = {qr[W-2:0], ~t[W]};
        state_n = state;
        if (state == IDLE)
            state_n = start ? ((y == '0) ? DONE : CALC) : IDLE;
        else if (state == CALC)
            state_n = (cnt == CW'(1)) ? DONE : CALC;
        else
            state_n = IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            a <= '0;
            qr <= '0;
            yr <= '0;
            cnt <= '0;
            q <= '0;
            r <= '0;
            dbz <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                if (y == '0) begin
                    q <= '1;
                    r <= x;
                    dbz <= 1'b1;
                end else begin
                    a <= '0;
                    qr <= x;
                    yr <= y;
                    cnt <= CW'(W);
                end
            end else if (state == CALC) begin
                a <= a_nx;
                qr <= q_sh;
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    q <= q_sh;
                    r <= a_nx[W-1:0];
                    dbz <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_booth_div.sv
// tb_booth_div: scoreboard bench; the driver queues expected results from an
// arithmetic model, and a negedge monitor pops and compares on every done.
module tb_booth_div;
    localparam int W = 4;
    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic dbz;
    } res_t;
    logic clk = 0, reset = 1, start = 0;
    logic [W-1:0] x = '0, y = '0;
    logic [W-1:0] q, r;
    logic done, busy, dbz;
    res_t exp_q[$];
    int checks = 0, errors = 0, dones = 0, accepted = 0;

    booth_div #(.W(W)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .start(start),
        .q(q), .r(r), .done(done), .busy(busy), .dbz(dbz)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input int a, input int b);
        res_t m;
        if (b == 0) begin
            m.q = '1;
            m.r = W'(a);
            m.dbz = 1'b1;
        end else begin
            m.q = W'(a / b);
            m.r = W'(a % b);
            m.dbz = 1'b0;
        end
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            dones++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: done with no outstanding operation at %0t", $time);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("q", q, e.q);
                check("r", r, e.r);
                check("dbz", dbz, e.dbz);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    task automatic issue(input int a, input int b);
        wait_idle();
        x = W'(a);
        y = W'(b);
        start = 1;
        exp_q.push_back(model(a, b));
        accepted++;
        @(negedge clk);
        start = 0;
    endtask

    task automatic timed(input int a, input int b, output int lat, output int bc);
        wait_idle();
        x = W'(a);
        y = W'(b);
        start = 1;
        exp_q.push_back(model(a, b));
        accepted++;
        lat = 0;
        bc = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) start = 0;
            if (busy) bc++;
            if (done && lat == 0) lat = i;
        end
    endtask

    initial begin
        int lat, bc, d0, idx;
        int dt[$];
        #12;
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_dbz", dbz, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        // done is seen on the W+1th negedge after start is raised (edge W)
        timed(13, 4, lat, bc);
        check("lat_norm", lat, W + 1);
        check("busy_norm", bc, W + 1);
        issue(15, 1);
        issue(3, 5);
        issue(15, 15);
        issue(0, 7);
        timed(7, 0, lat, bc);
        check("lat_dbz", lat, 1);
        check("busy_dbz", bc, 1);
        issue(9, 3);
        issue(13, 5);
        @(negedge clk);
        x = 9;
        y = 2;
        start = 1;
        @(negedge clk);
        start = 0;
        wait_idle();
        // start held high: expect one acceptance per return to IDLE
        x = 14;
        y = 3;
        start = 1;
        idx = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) begin
                exp_q.push_back(model(14, 3));
                accepted++;
            end
            @(negedge clk);
            idx++;
            if (done) dt.push_back(idx);
        end
        start = 0;
        check("hold_dones", (dt.size() >= 3) ? 1 : 0, 1);
        for (int i = 1; i < dt.size(); i++) check("hold_gap", dt[i] - dt[i-1], W + 2);
        wait_idle();
        @(negedge clk);
        x = 13;
        y = 4;
        start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        #2 reset = 1;
        #1;
        check("arst_q", q, 0);
        check("arst_r", r, 0);
        check("arst_dbz", dbz, 0);
        check("arst_done", done, 0);
        check("arst_busy", busy, 0);
        #1 reset = 0;
        d0 = dones;
        repeat (12) @(negedge clk);
        check("arst_no_done", dones, d0);
        issue(10, 3);
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                issue(a, b);
        for (int i = 0; i < 100; i++) issue($urandom_range(0, 15), $urandom_range(0, 15));
        lat = 0;
        while ((busy || exp_q.size() != 0) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("drain", exp_q.size(), 0);
        check("done_total", dones, accepted);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
